sprite_blitter: RTL and testbench

// Copies a rectangular sprite region from the sprite ROM into the frame buffer,
// one pixel per cycle. Supports horizontal mirroring, transparent-colour skipping,

---
 rtl/sprite_blitter_if.sv | 41 ++++
 rtl/sprite_blitter.sv | 156 +++++++++++++++
 tb/tb_sprite_blitter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_if.sv
// sprite_blitter_if: descriptor, handshake, ROM and frame-buffer write signals of
// the sprite blitter.
//   master: scene sequencer / ROM / frame-buffer side (drives start, descriptor,
//           rom_data, wr_ready; observes busy, done, rom_*, wr_*, write_*)
//   slave : the blitter itself
interface sprite_blitter_if #(
  parameter int COOR_WIDTH    = 12,
  parameter int ROM_WIDTH     = 19,
  parameter int PALETTE_WIDTH = 3
);
  logic                     start;
  logic [COOR_WIDTH-1:0]    sprite_x;
  logic [COOR_WIDTH-1:0]    sprite_y;
  logic [COOR_WIDTH-1:0]    frame_x;
  logic [COOR_WIDTH-1:0]    frame_y;
  logic [COOR_WIDTH-1:0]    width;
  logic [COOR_WIDTH-1:0]    height;
  logic                     mirror;
  logic                     busy;
  logic                     done;
  logic                     rom_en;
  logic [ROM_WIDTH-1:0]     rom_addr;
  logic [PALETTE_WIDTH-1:0] rom_data;
  logic                     wr_ready;
  logic                     wr_en;
  logic [COOR_WIDTH-1:0]    write_x;
  logic [COOR_WIDTH-1:0]    write_y;
  logic [PALETTE_WIDTH-1:0] write_palette;

  modport master (
    output start, sprite_x, sprite_y, frame_x, frame_y, width, height, mirror,
    output rom_data, wr_ready,
    input  busy, done, rom_en, rom_addr, wr_en, write_x, write_y, write_palette
  );

  modport slave (
    input  start, sprite_x, sprite_y, frame_x, frame_y, width, height, mirror,
    input  rom_data, wr_ready,
    output busy, done, rom_en, rom_addr, wr_en, write_x, write_y, write_palette
  );
endinterface

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a width x height region of the sprite ROM into the frame
// buffer, one pixel per cycle, with mirroring, transparency and frame clipping.
// Ports:
//   clk_33m  system clock
//   rst      synchronous, active-high reset
//   bus      sprite_blitter_if.slave (descriptor/start/busy/done, ROM read port,
//            frame-buffer write port with wr_ready back-pressure)
//
// state | meaning
// IDLE  | waiting for start, descriptor latched on start
// RUN   | issuing one ROM address per wr_ready cycle, row-major scan
// DRAIN | last address issued, waiting for the read pipeline to empty
// DONE  | one-cycle done pulse
module sprite_blitter #(
  parameter int COOR_WIDTH      = 12,
  parameter int ROM_WIDTH       = 19,
  parameter int PALETTE_WIDTH   = 3,
  parameter int SPRITE_WIDTH    = 2442,
  parameter int FRAME_WIDTH     = 1280,
  parameter int FRAME_HEIGHT    = 300,
  parameter int ROM_LATENCY     = 1,
  parameter int TRANSPARENT_EN  = 1,
  parameter int TRANSPARENT_IDX = 0
) (
  input logic             clk_33m,
  input logic             rst,
  sprite_blitter_if.slave bus
);
  localparam int CW = COOR_WIDTH;
  localparam int RW = ROM_WIDTH;
  localparam int PW = PALETTE_WIDTH;
  localparam int L  = ROM_LATENCY;
  localparam logic [RW-1:0] PITCH   = RW'(SPRITE_WIDTH);
  localparam logic [CW-1:0] FRAME_W = CW'(FRAME_WIDTH);
  localparam logic [CW-1:0] FRAME_H = CW'(FRAME_HEIGHT);
  localparam logic [PW-1:0] TRANSP  = PW'(TRANSPARENT_IDX);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   sx_q, sy_q, fx_q, fy_q, w_q, h_q;
  logic            mir_q;
  logic [CW-1:0]   x_q, x_d, y_q, y_d;
  logic [L-1:0]    vld_q, vld_d;
  logic [CW-1:0]   px_q [L];
  logic [CW-1:0]   py_q [L];
  logic            load, issue;

  logic [RW-1:0]   src_x, src_row;
  logic [CW:0]     wfx, wfy;
  logic            in_x, in_y, opaque, wr_en;

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      sx_q  <= '0;
      sy_q  <= '0;
      fx_q  <= '0;
      fy_q  <= '0;
      w_q   <= '0;
      h_q   <= '0;
      mir_q <= 1'b0;
    end else if (load) begin
      sx_q  <= bus.sprite_x;
      sy_q  <= bus.sprite_y;
      fx_q  <= bus.frame_x;
      fy_q  <= bus.frame_y;
      w_q   <= bus.width;
      h_q   <= bus.height;
      mir_q <= bus.mirror;
    end
  end

  // Coordinates ride alongside the ROM read; gated by vld_q, so no reset needed.
  always_ff @(posedge clk_33m) begin
    if (bus.wr_ready) begin
      px_q[0] <= x_q;
      py_q[0] <= y_q;
      for (int i = 1; i < L; i++) begin
        px_q[i] <= px_q[i-1];
        py_q[i] <= py_q[i-1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    load    = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          x_d     = '0;
          y_d     = '0;
          state_d = (bus.width == '0 || bus.height == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.wr_ready) begin
          issue = 1'b1;
          if (x_q == w_q - CW'(1)) begin
            x_d = '0;
            if (y_q == h_q - CW'(1)) state_d = DRAIN;
            else                     y_d     = y_q + CW'(1);
          end else begin
            x_d = x_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (vld_d == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Whole pipeline freezes on back-pressure so rom_data stays aligned with x/y.
  assign vld_d = bus.wr_ready ? ((vld_q << 1) | L'(issue)) : vld_q;

  assign src_x   = RW'(sx_q) + (mir_q ? (RW'(w_q) - RW'(x_q) - RW'(1)) : RW'(x_q));
  assign src_row = RW'(sy_q) + RW'(y_q);

  // Frame position: sign-extended frame origin plus unsigned offset.
  assign wfx    = {fx_q[CW-1], fx_q} + {1'b0, px_q[L-1]};
  assign wfy    = {fy_q[CW-1], fy_q} + {1'b0, py_q[L-1]};
  assign in_x   = !wfx[CW] && (wfx[CW-1:0] < FRAME_W);
  assign in_y   = !wfy[CW] && (wfy[CW-1:0] < FRAME_H);
  assign opaque = !((TRANSPARENT_EN != 0) && (bus.rom_data == TRANSP));
  assign wr_en  = vld_q[L-1] && in_x && in_y && opaque;

  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == DONE);
  assign bus.rom_en        = (state_q == RUN) && bus.wr_ready;
  assign bus.rom_addr      = (state_q == RUN) ? (src_row * PITCH + src_x) : '0;
  assign bus.wr_en         = wr_en;
  assign bus.write_x       = wr_en ? wfx[CW-1:0] : '0;
  assign bus.write_y       = wr_en ? wfy[CW-1:0] : '0;
  assign bus.write_palette = wr_en ? bus.rom_data : '0;
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: drives two blitters (ROM_LATENCY 1 and 3) with the same
// descriptors and wr_ready pattern, and checks writes, addresses and done timing
// against a pixel-list model.
module tb_sprite_blitter;
  localparam int CW = 12;
  localparam int RW = 19;
  localparam int PW = 3;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [PW-1:0] p;
  } wr_t;

  logic clk_33m = 1'b0;
  logic rst     = 1'b1;
  always #15 clk_33m = ~clk_33m;

  logic          start    = 1'b0;
  logic [CW-1:0] d_sx = '0, d_sy = '0, d_fx = '0, d_fy = '0, d_w = '0, d_h = '0;
  logic          d_mir    = 1'b0;
  logic          wr_ready = 1'b1;
  int            rom_mode = 0;
  bit            rdy_pat [0:255];

  sprite_blitter_if #(.COOR_WIDTH(CW), .ROM_WIDTH(RW), .PALETTE_WIDTH(PW)) b1 ();
  sprite_blitter_if #(.COOR_WIDTH(CW), .ROM_WIDTH(RW), .PALETTE_WIDTH(PW)) b3 ();

  sprite_blitter #(.ROM_LATENCY(1)) dut1 (.clk_33m(clk_33m), .rst(rst), .bus(b1));
  sprite_blitter #(.ROM_LATENCY(3)) dut3 (.clk_33m(clk_33m), .rst(rst), .bus(b3));

  assign b1.start = start;  assign b3.start = start;
  assign b1.sprite_x = d_sx; assign b3.sprite_x = d_sx;
  assign b1.sprite_y = d_sy; assign b3.sprite_y = d_sy;
  assign b1.frame_x = d_fx;  assign b3.frame_x = d_fx;
  assign b1.frame_y = d_fy;  assign b3.frame_y = d_fy;
  assign b1.width = d_w;     assign b3.width = d_w;
  assign b1.height = d_h;    assign b3.height = d_h;
  assign b1.mirror = d_mir;  assign b3.mirror = d_mir;
  assign b1.wr_ready = wr_ready; assign b3.wr_ready = wr_ready;

  function automatic logic [PW-1:0] rom_f(input int mode, input logic [RW-1:0] a);
    case (mode)
      0:       return a[2:0];
      1:       return a[2:0] ^ a[5:3] ^ a[9:7];
      default: return a[0] ? (a[3:1] | 3'd1) : 3'd0;
    endcase
  endfunction

  // ROM models: latency-1 register holding while not enabled; latency-3 pipe
  // that advances with the frame-buffer ready, like the blitter's own stages.
  logic [PW-1:0] rom1 = '0;
  logic [PW-1:0] r3a = '0, r3b = '0, r3c = '0;
  always @(posedge clk_33m) begin
    if (b1.rom_en) rom1 <= rom_f(rom_mode, b1.rom_addr);
    if (wr_ready) begin
      if (b3.rom_en) r3a <= rom_f(rom_mode, b3.rom_addr);
      r3b <= r3a;
      r3c <= r3b;
    end
  end
  assign b1.rom_data = rom1;
  assign b3.rom_data = r3c;

  int cyc = 0;
  always @(posedge clk_33m) cyc <= cyc + 1;

  wr_t           got1[$], got3[$];
  logic [RW-1:0] adr1[$], adr3[$];
  int            done1_cyc = -1, done3_cyc = -1, done1_n = 0, done3_n = 0;
  always @(negedge clk_33m) begin
    if (b1.wr_en && wr_ready) got1.push_back({b1.write_x, b1.write_y, b1.write_palette});
    if (b3.wr_en && wr_ready) got3.push_back({b3.write_x, b3.write_y, b3.write_palette});
    if (b1.rom_en) adr1.push_back(b1.rom_addr);
    if (b3.rom_en) adr3.push_back(b3.rom_addr);
    if (b1.done) begin done1_cyc = cyc; done1_n++; end
    if (b3.done) begin done3_cyc = cyc; done3_n++; end
  end

  logic [27:0] snap1, snap3;
  assign snap1 = {b1.wr_en, b1.write_x, b1.write_y, b1.write_palette};
  assign snap3 = {b3.wr_en, b3.write_x, b3.write_y, b3.write_palette};

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_33m);
    #1;
  endtask

  function automatic int exp_done(input int n, input int lat);
    int rem;
    if (n == 0) return 1;
    rem = n + lat;
    for (int c = 1; c < 256; c++) begin
      if (rdy_pat[c]) rem--;
      if (rem == 0) return c + 1;
    end
    return -1;
  endfunction

  task automatic all_ready();
    for (int c = 0; c < 256; c++) rdy_pat[c] = 1'b1;
  endtask

  task automatic run_element(input string tag, input int w, input int h,
                             input int sx, input int sy, input int fx, input int fy,
                             input bit mir, input int mode, input bit restart);
    wr_t           exp_q[$];
    logic [RW-1:0] exp_a[$];
    int d1, d3, s, bg1, bg3, ba1, ba3, bd1, bd3;
    logic [27:0] prev1, prev3;
    d1 = exp_done(w * h, 1);
    d3 = exp_done(w * h, 3);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        int a, fxx, fyy;
        logic [RW-1:0] av;
        logic [PW-1:0] p;
        wr_t e;
        a  = ((sy + y) * 2442 + sx + (mir ? (w - 1 - x) : x)) % (1 << RW);
        av = RW'(a);
        exp_a.push_back(av);
        p   = rom_f(mode, av);
        fxx = fx + x;
        fyy = fy + y;
        if (fxx >= 0 && fxx < 1280 && fyy >= 0 && fyy < 300 && p != 3'd0) begin
          e.x = CW'(fxx); e.y = CW'(fyy); e.p = p;
          exp_q.push_back(e);
        end
      end
    end
    bg1 = got1.size(); bg3 = got3.size(); ba1 = adr1.size(); ba3 = adr3.size();
    bd1 = done1_n; bd3 = done3_n;
    rom_mode = mode;
    d_sx = CW'(sx); d_sy = CW'(sy); d_fx = CW'(fx); d_fy = CW'(fy);
    d_w = CW'(w); d_h = CW'(h); d_mir = mir;
    start = 1'b1;
    wr_ready = rdy_pat[0];
    s = cyc;
    prev1 = snap1; prev3 = snap3;
    for (int c = 1; c <= d3 + 2; c++) begin
      step();
      if (!rdy_pat[c-1]) begin
        chk({tag, " L1 hold in stall"}, 64'(snap1), 64'(prev1));
        chk({tag, " L3 hold in stall"}, 64'(snap3), 64'(prev3));
      end
      prev1 = snap1; prev3 = snap3;
      start = restart && (c == 2);
      if (restart && c == 2) begin
        d_sx = CW'($urandom); d_sy = CW'($urandom); d_fx = CW'($urandom);
        d_fy = CW'($urandom); d_w = CW'($urandom_range(1, 50));
        d_h = CW'($urandom_range(1, 50)); d_mir = ~d_mir;
      end
      wr_ready = rdy_pat[c];
    end
    chk({tag, " L1 done count"}, 64'(done1_n - bd1), 64'd1);
    chk({tag, " L3 done count"}, 64'(done3_n - bd3), 64'd1);
    chk({tag, " L1 done cycle"}, 64'(done1_cyc - s), 64'(d1));
    chk({tag, " L3 done cycle"}, 64'(done3_cyc - s), 64'(d3));
    chk({tag, " L1 write count"}, 64'(got1.size() - bg1), 64'(exp_q.size()));
    chk({tag, " L3 write count"}, 64'(got3.size() - bg3), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (bg1 + i < got1.size()) chk({tag, " L1 write"}, 64'(got1[bg1 + i]), 64'(exp_q[i]));
      if (bg3 + i < got3.size()) chk({tag, " L3 write"}, 64'(got3[bg3 + i]), 64'(exp_q[i]));
    end
    chk({tag, " L1 addr count"}, 64'(adr1.size() - ba1), 64'(exp_a.size()));
    chk({tag, " L3 addr count"}, 64'(adr3.size() - ba3), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size(); i++) begin
      if (ba1 + i < adr1.size()) chk({tag, " L1 addr"}, 64'(adr1[ba1 + i]), 64'(exp_a[i]));
      if (ba3 + i < adr3.size()) chk({tag, " L3 addr"}, 64'(adr3[ba3 + i]), 64'(exp_a[i]));
    end
    chk({tag, " L1 idle after"}, 64'(b1.busy), 64'd0);
    chk({tag, " L3 idle after"}, 64'(b3.busy), 64'd0);
  endtask

  initial begin
    int s, bd1, bd3;
    all_ready();
    rst = 1'b1;
    repeat (3) step();
    chk("reset L1 outputs", 64'({b1.busy, b1.done, b1.rom_en, b1.rom_addr, b1.wr_en,
                                 b1.write_x, b1.write_y, b1.write_palette}), 64'd0);
    chk("reset L3 outputs", 64'({b3.busy, b3.done, b3.rom_en, b3.rom_addr, b3.wr_en,
                                 b3.write_x, b3.write_y, b3.write_palette}), 64'd0);
    rst = 1'b0;
    step();

    run_element("plain",  4, 2, 10, 0, 5, 5, 1'b0, 0, 1'b0);
    run_element("mirror", 4, 2, 10, 0, 5, 5, 1'b1, 0, 1'b0);
    run_element("clip",   4, 4, 100, 3, -2, 298, 1'b0, 0, 1'b0);
    rdy_pat[3] = 1'b0; rdy_pat[4] = 1'b0; rdy_pat[5] = 1'b0;
    run_element("transp_stall", 4, 2, 10, 0, 5, 5, 1'b0, 2, 1'b0);
    all_ready();
    run_element("zero_w", 0, 3, 10, 0, 5, 5, 1'b0, 0, 1'b0);
    run_element("restart", 4, 2, 10, 0, 5, 5, 1'b0, 0, 1'b1);

    // Reset in the middle of RUN: write stops next cycle, no done afterwards.
    bd1 = done1_n; bd3 = done3_n;
    rom_mode = 0;
    d_sx = 12'd10; d_sy = '0; d_fx = 12'd5; d_fy = 12'd5; d_w = 12'd3; d_h = 12'd3;
    d_mir = 1'b0; wr_ready = 1'b1; start = 1'b1;
    s = cyc;
    step(); start = 1'b0;
    repeat (3) step();
    chk("rst_run L1 writing before reset", 64'(b1.wr_en), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_run L1 wr_en", 64'(b1.wr_en), 64'd0);
    chk("rst_run L3 wr_en", 64'(b3.wr_en), 64'd0);
    chk("rst_run L1 busy", 64'(b1.busy), 64'd0);
    chk("rst_run L3 busy", 64'(b3.busy), 64'd0);
    repeat (20) step();
    chk("rst_run L1 no done", 64'(done1_n - bd1), 64'd0);
    chk("rst_run L3 no done", 64'(done3_n - bd3), 64'd0);

    for (int t = 0; t < 25; t++) begin
      for (int c = 0; c < 256; c++) rdy_pat[c] = (c >= 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
      begin
        int w, h;
        w = $urandom_range(0, 6);
        h = $urandom_range(0, 4);
        run_element("random", w, h, $urandom_range(0, 4095), $urandom_range(0, 4095),
                    int'($urandom_range(0, 1298)) - 8, int'($urandom_range(0, 313)) - 8,
                    1'($urandom_range(0, 1)), 1, (w * h > 0) && ($urandom_range(0, 3) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
